// File: rtl/acq_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : acq_sequencer_pkg                                      |
// | Description : Shared state encoding and counter width default for    |
// |               the acquisition sequencer.                             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package acq_sequencer_pkg;

    localparam int W_CNT_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_DELAY     = 3'd2,
        ST_GATE      = 3'd3,
        ST_PULSE_END = 3'd4,
        ST_DONE      = 3'd5
    } acq_state_t;

endpackage
`default_nettype wire

// File: rtl/acq_bin_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : acq_bin_counter                                        |
// | Description : Point-within-bin and bin counters for the gated        |
// |               window, with first/last qualifiers.                    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module acq_bin_counter
    import acq_sequencer_pkg::*;
#(
    parameter int W_CNT = W_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [W_CNT-1:0] n_points_rb,
    input  logic [W_CNT-1:0] n_range_bins,
    output logic [W_CNT-1:0] bin_idx,
    output logic             point_first,
    output logic             point_last,
    output logic             bin_final
);

    localparam logic [W_CNT-1:0] C_ONE = W_CNT'(1);

    logic [W_CNT-1:0] r_point_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_point_idx <= '0;
            bin_idx     <= '0;
        end else if (clear) begin
            r_point_idx <= '0;
            bin_idx     <= '0;
        end else if (advance) begin
            if (point_last) begin
                r_point_idx <= '0;
                bin_idx     <= bin_idx + C_ONE;
            end else begin
                r_point_idx <= r_point_idx + C_ONE;
            end
        end
    end

    assign point_first = (r_point_idx == '0);
    assign point_last  = (r_point_idx == n_points_rb - C_ONE);
    assign bin_final   = (bin_idx == n_range_bins - C_ONE);

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : acq_sequencer                                          |
// | Description : Trigger-driven range-gate sequencer accumulating a     |
// |               configurable number of laser pulses per run.           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int W_CNT = W_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             trig_in,
    input  logic [W_CNT-1:0] cfg_mirror_start,
    input  logic [W_CNT-1:0] cfg_end_position,
    input  logic [W_CNT-1:0] cfg_n_range_bins,
    input  logic [W_CNT-1:0] cfg_n_points_rb,
    input  logic [W_CNT-1:0] cfg_n_acc_pulses,
    output logic             cmd_update_disable,
    output logic             busy,
    output logic             gate,
    output logic             bin_first,
    output logic             bin_last,
    output logic [W_CNT-1:0] bin_idx,
    output logic [W_CNT-1:0] pulse_idx,
    output logic             pulse_first,
    output logic             pulse_last,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [W_CNT-1:0] C_ONE = W_CNT'(1);

    acq_state_t       r_state;
    logic             r_trig_d;
    logic [W_CNT-1:0] r_samp;
    logic [W_CNT-1:0] r_ms;
    logic [W_CNT-1:0] r_end;
    logic [W_CNT-1:0] r_nbins;
    logic [W_CNT-1:0] r_npts;
    logic [W_CNT-1:0] r_nacc;
    logic [W_CNT-1:0] r_pulse_idx;
    logic             r_busy;
    logic             r_gate;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_trig_edge;
    logic             w_cfg_ok;
    logic [W_CNT-1:0] w_samp_next;
    logic             w_trunc;
    logic             w_gate_end;
    logic             w_cnt_clear;
    logic             w_cnt_advance;
    logic             w_point_first;
    logic             w_point_last;
    logic             w_bin_final;

    assign w_trig_edge = trig_in & ~r_trig_d;
    assign w_cfg_ok    = (cfg_n_range_bins != '0) && (cfg_n_points_rb != '0) &&
                         (cfg_n_acc_pulses != '0) && (cfg_mirror_start < cfg_end_position);
    assign w_samp_next = r_samp + C_ONE;
    assign w_trunc     = (r_samp == r_end - C_ONE);
    assign w_gate_end  = w_trunc | (w_point_last & w_bin_final);

    // Counters sit at zero outside the gate so the first gated sample is point 0 of bin 0.
    assign w_cnt_clear   = (r_state != ST_GATE) | abort;
    assign w_cnt_advance = ~w_cnt_clear & ~w_gate_end;

    acq_bin_counter #(
        .W_CNT (W_CNT)
    ) u_bin_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_cnt_clear),
        .advance      (w_cnt_advance),
        .n_points_rb  (r_npts),
        .n_range_bins (r_nbins),
        .bin_idx      (bin_idx),
        .point_first  (w_point_first),
        .point_last   (w_point_last),
        .bin_final    (w_bin_final)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_trig_d    <= 1'b0;
            r_samp      <= '0;
            r_ms        <= '0;
            r_end       <= '0;
            r_nbins     <= '0;
            r_npts      <= '0;
            r_nacc      <= '0;
            r_pulse_idx <= '0;
            r_busy      <= 1'b0;
            r_gate      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_trig_d <= trig_in;
            r_done   <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_gate  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (w_cfg_ok) begin
                                r_ms        <= cfg_mirror_start;
                                r_end       <= cfg_end_position;
                                r_nbins     <= cfg_n_range_bins;
                                r_npts      <= cfg_n_points_rb;
                                r_nacc      <= cfg_n_acc_pulses;
                                r_pulse_idx <= '0;
                                r_cfg_err   <= 1'b0;
                                r_busy      <= 1'b1;
                                r_state     <= ST_WAIT_TRIG;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (w_trig_edge) begin
                            r_samp <= '0;
                            if (r_ms == '0) begin
                                r_gate  <= 1'b1;
                                r_state <= ST_GATE;
                            end else begin
                                r_state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        r_samp <= w_samp_next;
                        if (w_samp_next == r_ms) begin
                            r_gate  <= 1'b1;
                            r_state <= ST_GATE;
                        end
                    end
                    ST_GATE: begin
                        if (w_gate_end) begin
                            r_gate  <= 1'b0;
                            r_state <= ST_PULSE_END;
                        end else begin
                            r_samp <= w_samp_next;
                        end
                    end
                    ST_PULSE_END: begin
                        if (r_pulse_idx + C_ONE < r_nacc) begin
                            r_pulse_idx <= r_pulse_idx + C_ONE;
                            r_state     <= ST_WAIT_TRIG;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_gate  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy               = r_busy;
    assign cmd_update_disable = r_busy;
    assign gate               = r_gate;
    assign done               = r_done;
    assign cfg_err            = r_cfg_err;
    assign pulse_idx          = r_pulse_idx;
    // A truncated gate closes its last bin on whatever point it happens to reach.
    assign bin_first          = r_gate & w_point_first;
    assign bin_last           = r_gate & (w_point_last | w_trunc);
    assign pulse_first        = r_gate & (r_pulse_idx == '0);
    assign pulse_last         = r_gate & (r_pulse_idx == r_nacc - C_ONE);

endmodule
`default_nettype wire

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter: W_CNT, default 16, width of all config fields and counters.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin an acquisition run (from UR_CMD decode).
REQ-005 abort  in  1  one-cycle request to terminate the current run.
REQ-006 trig_in  in  1  laser-pulse trigger, synchronous to clk, level.
REQ-007 cfg_mirror_start  in  W_CNT  samples from trigger to first gated sample.
REQ-008 cfg_end_position  in  W_CNT  absolute sample index (from trigger) at which the gate is forced closed.
REQ-009 cfg_n_range_bins  in  W_CNT  range bins per pulse.
REQ-010 cfg_n_points_rb  in  W_CNT  samples per range bin.
REQ-011 cfg_n_acc_pulses  in  W_CNT  pulses accumulated per run.
REQ-012 cmd_update_disable  out  1  high while a run is active; freezes the register-latch block.
REQ-013 busy  out  1  state not IDLE.
REQ-014 gate  out  1  current sample belongs to a range bin.
REQ-015 bin_first / bin_last  out  1 each  qualify first/last gated sample of a bin.
REQ-016 bin_idx  out  W_CNT  current bin index; pulse_idx  out  W_CNT  current pulse index.
REQ-017 pulse_first / pulse_last  out  1 each  high throughout the gate of pulse 0 / pulse n_acc_pulses-1.
REQ-018 done  out  1  one-cycle pulse when a run completes normally.
REQ-019 cfg_err  out  1  sticky until next accepted start; set when start is rejected.

Function
REQ-020 States: IDLE, WAIT_TRIG, DELAY, GATE, PULSE_END, DONE.
REQ-021 IDLE: start with all of n_range_bins, n_points_rb, n_acc_pulses nonzero and mirror_start < end_position -> WAIT_TRIG, cfg_err cleared, pulse_idx=0; otherwise stay IDLE, set cfg_err.
REQ-022 Config inputs shall be sampled into internal registers on the accepted start; later changes have no effect on the run.
REQ-023 WAIT_TRIG: rising edge of trig_in (trig_in high, previous-cycle low) -> DELAY (or GATE if mirror_start==0); sample counter cleared to 0 in the first cycle after the edge.
REQ-024 Sample counter increments every cycle in DELAY and GATE; sample index 0 is the cycle after the edge cycle.
REQ-025 DELAY -> GATE when sample counter reaches mirror_start; gate high from that cycle.
REQ-026 GATE: point counter 0..n_points_rb-1, wraps and increments bin_idx; bin_first at point 0, bin_last at point n_points_rb-1.
REQ-027 GATE ends after the last point of bin n_range_bins-1, or at sample index end_position-1, whichever first; truncation asserts bin_last on the final gated sample.
REQ-028 PULSE_END (one cycle, gate low): pulse_idx+1 < n_acc_pulses -> increment pulse_idx, WAIT_TRIG; else DONE.
REQ-029 DONE: done high one cycle -> IDLE.
REQ-030 Trigger edges outside WAIT_TRIG shall be ignored.
REQ-031 abort in any non-IDLE state -> IDLE next cycle, gate low, done not asserted; abort wins over simultaneous trigger or gate end.
REQ-032 start while busy shall be ignored; start and abort in same IDLE cycle: abort wins, start ignored.
REQ-033 cmd_update_disable = busy, registered, no combinational path from inputs.
REQ-034 All counters W_CNT bits unsigned; comparisons use latched config; no counter wraps within a legal run.

Reset
REQ-035 rst asserted: state IDLE, all counters 0, all outputs 0, cfg_err 0, effective immediately and mid-run without done.

Structure
REQ-036 Shared package holds the state enumeration and W_CNT default.
REQ-037 Single sub-module natural: acq_bin_counter (point/bin counting with first/last flags); the rest flat.

Verification
REQ-038 mirror_start=4, n_points_rb=3, n_range_bins=2, n_acc_pulses=1, end=100; start, trigger -> gate high samples 4..9, bin_first at 4,7, bin_last at 6,9, done 2 cycles after sample 9.
REQ-039 Same config, n_acc_pulses=3, three triggers -> three gates, pulse_first on gate 1, pulse_last on gate 3, single done; extra trigger during a gate ignored.
REQ-040 end_position=8 with REQ-038 config -> gate samples 4..7, bin_last at 7, bin_idx 1 at truncation.
REQ-041 n_points_rb=0 start -> stay IDLE, cfg_err=1, busy=0; subsequent valid start clears cfg_err.
REQ-042 abort at sample 5 of gate -> IDLE next cycle, gate/busy/cmd_update_disable low, no done.
REQ-043 rst asserted mid-gate asynchronously -> all outputs 0 before next clock edge.
